// File: rtl/i2s_pkg.sv
// Shared types and constants for the I2S TX push-port arbiter.
package i2s_pkg;

   typedef enum logic {
      ARB_IDLE = 1'b0,
      ARB_LOCK = 1'b1
   } i2s_arb_state_e;

   localparam int TIMEOUT_DEFAULT = 64;
   localparam int ERR_CNT_WIDTH   = 8;

endpackage

// File: rtl/i2s_rr_pick.sv
// Rotate-priority picker: first valid requester at or after start, wrapping modulo NUM_REQ.
module i2s_rr_pick #(
   parameter int NUM_REQ     = 4,
   parameter int LOG_NUM_REQ = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]     valid,
   input  logic [LOG_NUM_REQ-1:0] start,
   output logic [NUM_REQ-1:0]     grant,
   output logic [LOG_NUM_REQ-1:0] index,
   output logic                   any_valid
);

   always_comb begin
      logic [LOG_NUM_REQ-1:0] pos;
      grant     = '0;
      index     = '0;
      any_valid = 1'b0;
      pos       = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         pos = LOG_NUM_REQ'((int'(start) + k) % NUM_REQ);
         if (!any_valid && valid[pos]) begin
            any_valid  = 1'b1;
            grant[pos] = 1'b1;
            index      = pos;
         end
      end
   end

endmodule

// File: rtl/i2s_tx_arb.sv
// Round-robin arbiter for the I2S TX fifo push port; stereo mode locks the grant for a L/R pair.
//
// state    | meaning
// ARB_IDLE | rotate-priority grant among all valid requesters
// ARB_LOCK | first word of a pair taken; only the owner may push, watchdog running
module i2s_tx_arb
   import i2s_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int DATA_WIDTH  = 32,
   parameter int TIMEOUT     = TIMEOUT_DEFAULT,
   parameter int LOG_NUM_REQ = $clog2(NUM_REQ)
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic                          en_i,
   input  logic                          flush_i,
   input  logic                          stereo_i,
   input  logic [NUM_REQ-1:0]            req_valid_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i,
   output logic [NUM_REQ-1:0]            req_ready_o,
   input  logic                          fifo_full_i,
   output logic                          fifo_push_o,
   output logic [DATA_WIDTH-1:0]         fifo_dat_o,
   output logic [NUM_REQ-1:0]            grant_o,
   output logic                          busy_o,
   output logic                          err_o,
   output logic [ERR_CNT_WIDTH-1:0]      err_cnt_o
);

   localparam int              TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);

   i2s_arb_state_e             state_q, state_d;
   logic [LOG_NUM_REQ-1:0]     rr_q, rr_d;
   logic [LOG_NUM_REQ-1:0]     owner_q, owner_d;
   logic [TW-1:0]              timer_q, timer_d;
   logic                       err_q, err_d;
   logic [ERR_CNT_WIDTH-1:0]   err_cnt_q, err_cnt_d;

   logic [NUM_REQ-1:0]         pick_gnt;
   logic [LOG_NUM_REQ-1:0]     pick_idx;
   logic                       pick_any;
   logic                       push_ok;
   logic                       owner_valid;
   logic                       lock_stall;

   function automatic logic [LOG_NUM_REQ-1:0] ptr_inc(input logic [LOG_NUM_REQ-1:0] p);
      return (int'(p) == NUM_REQ - 1) ? '0 : p + LOG_NUM_REQ'(1);
   endfunction

   i2s_rr_pick #(
      .NUM_REQ     (NUM_REQ),
      .LOG_NUM_REQ (LOG_NUM_REQ)
   ) u_pick (
      .valid     (req_valid_i),
      .start     (rr_q),
      .grant     (pick_gnt),
      .index     (pick_idx),
      .any_valid (pick_any)
   );

   // Reset also masks the combinational path so nothing leaks out while rst_n_i is low.
   assign push_ok     = en_i & rst_n_i & ~fifo_full_i;
   assign owner_valid = req_valid_i[owner_q];
   assign lock_stall  = ~owner_valid & ~fifo_full_i & en_i;

   always_comb begin
      grant_o = '0;
      if (push_ok) begin
         if (state_q == ARB_IDLE) begin
            if (pick_any) grant_o = pick_gnt;
         end else if (owner_valid) begin
            grant_o[owner_q] = 1'b1;
         end
      end
   end

   assign fifo_push_o = |grant_o;
   assign req_ready_o = grant_o & {NUM_REQ{fifo_push_o}};

   always_comb begin
      fifo_dat_o = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_o[i]) fifo_dat_o = req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_comb begin
      state_d   = state_q;
      rr_d      = rr_q;
      owner_d   = owner_q;
      timer_d   = timer_q;
      err_d     = 1'b0;
      err_cnt_d = err_cnt_q;
      if (en_i) begin
         case (state_q)
            ARB_IDLE: begin
               if (fifo_push_o) begin
                  if (stereo_i) begin
                     state_d = ARB_LOCK;
                     owner_d = pick_idx;
                     timer_d = '0;
                  end else begin
                     rr_d = ptr_inc(pick_idx);
                  end
               end
            end
            ARB_LOCK: begin
               // A push in the terminal cycle completes the pair, so it beats the timeout.
               if (fifo_push_o) begin
                  state_d = ARB_IDLE;
                  rr_d    = ptr_inc(owner_q);
               end else if (lock_stall) begin
                  if (timer_q == TIMER_LAST) begin
                     state_d   = ARB_IDLE;
                     rr_d      = ptr_inc(owner_q);
                     err_d     = 1'b1;
                     err_cnt_d = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + ERR_CNT_WIDTH'(1);
                  end else begin
                     timer_d = timer_q + TW'(1);
                  end
               end
            end
            default: state_d = ARB_IDLE;
         endcase
      end
      if (flush_i) begin
         state_d   = ARB_IDLE;
         rr_d      = '0;
         timer_d   = '0;
         err_d     = 1'b0;
         err_cnt_d = err_cnt_q;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q   <= ARB_IDLE;
         rr_q      <= '0;
         owner_q   <= '0;
         timer_q   <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rr_q      <= rr_d;
         owner_q   <= owner_d;
         timer_q   <= timer_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

   assign busy_o    = (state_q == ARB_LOCK);
   assign err_o     = err_q;
   assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_i2s_tx_arb.sv
// Scoreboard bench for i2s_tx_arb: producer queues feed the DUT, expected pushes are compared in order.
module tb_i2s_tx_arb;

   localparam int NR = 4;
   localparam int DW = 32;
   localparam int TO = 64;

   typedef struct {
      logic [NR-1:0] gnt;
      logic [DW-1:0] dat;
   } exp_t;

   logic            clk;
   logic            rst_n;
   logic            en;
   logic            flush;
   logic            stereo;
   logic [NR-1:0]   req_valid;
   logic [NR*DW-1:0] req_data;
   logic [NR-1:0]   req_ready;
   logic            fifo_full;
   logic            fifo_push;
   logic [DW-1:0]   fifo_dat;
   logic [NR-1:0]   grant;
   logic            busy;
   logic            err;
   logic [7:0]      err_cnt;

   int              checks;
   int              failures;
   int              cyc;
   int              err_pulses;
   logic [DW-1:0]   srcq [NR][$];
   exp_t            sb [$];

   i2s_tx_arb #(.NUM_REQ(NR), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .en_i        (en),
      .flush_i     (flush),
      .stereo_i    (stereo),
      .req_valid_i (req_valid),
      .req_data_i  (req_data),
      .req_ready_o (req_ready),
      .fifo_full_i (fifo_full),
      .fifo_push_o (fifo_push),
      .fifo_dat_o  (fifo_dat),
      .grant_o     (grant),
      .busy_o      (busy),
      .err_o       (err),
      .err_cnt_o   (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic refresh();
      for (int i = 0; i < NR; i++) begin
         req_valid[i]         = (srcq[i].size() != 0);
         req_data[i*DW +: DW] = (srcq[i].size() != 0) ? srcq[i][0] : '0;
      end
   endtask

   task automatic send(input int idx, input logic [DW-1:0] d);
      exp_t e;
      srcq[idx].push_back(d);
      e.gnt = NR'(1 << idx);
      e.dat = d;
      sb.push_back(e);
   endtask

   // One clock: sample handshakes away from the edge, then retire accepted words.
   task automatic step(input int n = 1);
      logic [NR-1:0] x;
      for (int s = 0; s < n; s++) begin
         @(negedge clk);
         x = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < NR; i++)
            if (x[i] && srcq[i].size() != 0) void'(srcq[i].pop_front());
         refresh();
      end
   endtask

   initial begin
      cyc = 0;
      forever begin
         @(posedge clk);
         cyc++;
      end
   end

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (err) err_pulses++;
         if (fifo_push) begin
            if (sb.size() == 0) begin
               chk("push_unexpected", 1, 0);
            end else begin
               e = sb.pop_front();
               chk("push_grant", grant, e.gnt);
               chk("push_data", fifo_dat, e.dat);
            end
         end
      end
   end

   initial begin
      int t0;
      int ep0;
      logic [7:0] cnt0;
      checks = 0; failures = 0; err_pulses = 0;
      rst_n = 1'b0; en = 1'b1; flush = 1'b0; stereo = 1'b0; fifo_full = 1'b0;
      req_valid = '1; req_data = '1;

      // reset: combinational outputs masked, registers cleared
      @(posedge clk); #1;
      @(posedge clk); #1;
      chk("rst_grant", grant, 0);
      chk("rst_push", fifo_push, 0);
      chk("rst_ready", req_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_err_cnt", err_cnt, 0);
      refresh();
      rst_n = 1'b1;
      step();

      // mono round robin, all four valid
      for (int i = 0; i < NR; i++) send(i, 32'h100 + i);
      for (int i = 0; i < NR; i++) send(i, 32'h200 + i);
      refresh();
      step(8);
      chk("mono_busy", busy, 0);

      // stereo pairs from req1 and req2
      stereo = 1'b1;
      send(1, 32'hA1); send(1, 32'hB1); send(2, 32'hA2); send(2, 32'hB2);
      refresh();
      step(); chk("pair1_busy_hi", busy, 1);
      step(); chk("pair1_busy_lo", busy, 0);
      step(); chk("pair2_busy_hi", busy, 1);
      step(); chk("pair2_busy_lo", busy, 0);

      // watchdog: req0 sends one word of a pair then goes silent
      send(0, 32'hC0);
      refresh();
      step();
      t0 = cyc;
      chk("to_busy", busy, 1);
      for (int n = 0; n < 100 && !err; n++) step();
      chk("to_delay", cyc - t0, TO);
      chk("to_err_cnt", err_cnt, 1);
      chk("to_busy_lo", busy, 0);
      step();
      chk("to_err_width", err, 0);
      stereo = 1'b0;
      send(1, 32'hC1); send(0, 32'hC2);
      refresh();
      step(2);

      // fifo full stall inside a lock must not age the watchdog
      stereo = 1'b1;
      ep0 = err_pulses;
      send(2, 32'hD0);
      refresh();
      step();
      chk("full_busy", busy, 1);
      fifo_full = 1'b1;
      step(100);
      send(2, 32'hD1);
      refresh();
      chk("full_grant", grant, 0);
      chk("full_push", fifo_push, 0);
      fifo_full = 1'b0;
      step();
      chk("full_busy_lo", busy, 0);
      chk("full_no_err", err_pulses - ep0, 0);
      stereo = 1'b0;
      send(3, 32'hD3); send(0, 32'hD4);
      refresh();
      step(2);

      // second word arrives in the terminal watchdog cycle
      stereo = 1'b1;
      cnt0 = err_cnt;
      ep0 = err_pulses;
      send(0, 32'hE0);
      refresh();
      step();
      step(TO - 1);
      chk("edge_busy", busy, 1);
      send(0, 32'hE1);
      refresh();
      step();
      chk("edge_busy_lo", busy, 0);
      chk("edge_err", err, 0);
      chk("edge_err_cnt", err_cnt, cnt0);
      step();
      chk("edge_no_err", err_pulses - ep0, 0);

      // flush during a lock with rr_ptr at 2
      stereo = 1'b0;
      send(1, 32'hF0);
      refresh();
      step();
      stereo = 1'b1;
      send(2, 32'hF1);
      refresh();
      step();
      chk("flush_busy_hi", busy, 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      chk("flush_busy_lo", busy, 0);
      chk("flush_err", err, 0);
      chk("flush_err_cnt", err_cnt, 1);
      stereo = 1'b0;
      for (int i = 0; i < NR; i++) send(i, 32'hF10 + i);
      refresh();
      step(4);

      // counter saturation across 300 timeouts
      stereo = 1'b1;
      ep0 = err_pulses;
      for (int n = 0; n < 300; n++) begin
         send(0, 32'h5000 + n);
         refresh();
         step(TO + 2);
      end
      chk("sat_pulses", err_pulses - ep0, 300);
      chk("sat_err_cnt", err_cnt, 255);

      // reset in the middle of a lock
      send(0, 32'h6000);
      refresh();
      step();
      chk("rstlock_busy", busy, 1);
      rst_n = 1'b0;
      step();
      chk("rstlock_busy_lo", busy, 0);
      chk("rstlock_err", err, 0);
      chk("rstlock_err_cnt", err_cnt, 0);
      rst_n = 1'b1;
      step(2);
      chk("rstlock_err_after", err, 0);

      chk("sb_drained", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
